// File: rtl/car_detector.sv
`default_nettype none
// ============================================================================
// Module      : car_detector
// Description : Country-road loop-sensor front end. Synchronises and debounces
//               the raw sensor, counts arriving cars, retires one queued car
//               every DEPART_CYCLES cycles of country GREEN, and raises the
//               car-waiting request X while the queue is non-empty.
// Revision    : 1.0 - initial release
// ============================================================================
module car_detector #(
   parameter int DEBOUNCE      = 3,   // stable samples to accept a level change (2..7)
   parameter int DEPART_CYCLES = 2,   // GREEN cycles per departing car (1..7)
   parameter int MAX_CARS      = 7    // queue saturation value (1..7)
) (
   input  logic       clock,
   input  logic       clear_n,
   input  logic       sensor,
   input  logic [1:0] cntry,
   output logic       X,
   output logic [2:0] car_count,
   output logic       overflow
);

   localparam logic [1:0] c_GREEN    = 2'd2;
   localparam logic [2:0] c_DEB_LAST = 3'(DEBOUNCE - 1);
   localparam logic [2:0] c_DEP_LAST = 3'(DEPART_CYCLES - 1);
   localparam logic [2:0] c_MAX_CARS = 3'(MAX_CARS);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_RISE_CHK = 2'd1,
      S_PRESENT  = 2'd2,
      S_FALL_CHK = 2'd3
   } deb_state_t;

   logic       r_sync1;
   logic       r_s_sync;
   deb_state_t r_state;
   deb_state_t w_next_state;
   logic [2:0] r_deb_cnt;
   logic [2:0] w_deb_cnt_next;
   logic       w_arrival;
   logic [2:0] r_dep_cnt;
   logic       w_dep_active;
   logic       w_departure;
   logic [2:0] r_car_count;
   logic       r_overflow;

   // Two-flop synchroniser: sensor is asynchronous to clock
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         r_sync1  <= 1'b0;
         r_s_sync <= 1'b0;
      end else begin
         r_sync1  <= sensor;
         r_s_sync <= r_sync1;
      end
   end

   // Debounce state and stability counter register
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         r_state   <= S_IDLE;
         r_deb_cnt <= 3'd0;
      end else begin
         r_state   <= w_next_state;
         r_deb_cnt <= w_deb_cnt_next;
      end
   end

   // Debounce next-state; an arrival is the RISE_CHK -> PRESENT transition
   always_comb begin
      w_next_state   = r_state;
      w_deb_cnt_next = r_deb_cnt;
      w_arrival      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_s_sync) begin
               w_next_state   = S_RISE_CHK;
               w_deb_cnt_next = 3'd1;
            end
         end
         S_RISE_CHK: begin
            if (!r_s_sync) begin
               w_next_state = S_IDLE;
            end else if (r_deb_cnt == c_DEB_LAST) begin
               w_next_state = S_PRESENT;
               w_arrival    = 1'b1;
            end else begin
               w_deb_cnt_next = r_deb_cnt + 3'd1;
            end
         end
         S_PRESENT: begin
            if (!r_s_sync) begin
               w_next_state   = S_FALL_CHK;
               w_deb_cnt_next = 3'd1;
            end
         end
         S_FALL_CHK: begin
            // A short low gap returns to PRESENT without counting a new car
            if (r_s_sync) begin
               w_next_state = S_PRESENT;
            end else if (r_deb_cnt == c_DEB_LAST) begin
               w_next_state = S_IDLE;
            end else begin
               w_deb_cnt_next = r_deb_cnt + 3'd1;
            end
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // The timer only runs while GREEN with cars queued; any other cycle drops progress
   assign w_dep_active = (cntry == c_GREEN) && (r_car_count != 3'd0);
   assign w_departure  = w_dep_active && (r_dep_cnt == c_DEP_LAST);

   // Departure timer
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         r_dep_cnt <= 3'd0;
      end else if (!w_dep_active || w_departure) begin
         r_dep_cnt <= 3'd0;
      end else begin
         r_dep_cnt <= r_dep_cnt + 3'd1;
      end
   end

   // Queue count with saturation and sticky overflow; simultaneous events cancel
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         r_car_count <= 3'd0;
         r_overflow  <= 1'b0;
      end else begin
         case ({w_arrival, w_departure})
            2'b10: begin
               if (r_car_count == c_MAX_CARS) begin
                  r_overflow <= 1'b1;
               end else begin
                  r_car_count <= r_car_count + 3'd1;
               end
            end
            2'b01: begin
               r_car_count <= r_car_count - 3'd1;
            end
            default: begin
               r_car_count <= r_car_count;
            end
         endcase
      end
   end

   // X decoded straight from the count register so it cannot glitch
   assign X         = (r_car_count != 3'd0);
   assign car_count = r_car_count;
   assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_car_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_car_detector
// Description : Self-checking bench for car_detector: per-cycle vector table,
//               hand-written multi-cycle sequences, and randomized traffic
//               compared against a behavioural queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_car_detector;

   localparam int DEBOUNCE      = 3;
   localparam int DEPART_CYCLES = 2;
   localparam int MAX_CARS      = 7;
   localparam logic [1:0] RED    = 2'd0;
   localparam logic [1:0] YELLOW = 2'd1;
   localparam logic [1:0] GREEN  = 2'd2;
   localparam int NVEC = 26;

   logic       clock   = 1'b0;
   logic       clear_n = 1'b0;
   logic       sensor  = 1'b0;
   logic [1:0] cntry   = RED;
   logic       X;
   logic [2:0] car_count;
   logic       overflow;

   int total = 0;
   int bad   = 0;

   car_detector #(
      .DEBOUNCE      (DEBOUNCE),
      .DEPART_CYCLES (DEPART_CYCLES),
      .MAX_CARS      (MAX_CARS)
   ) dut (
      .clock     (clock),
      .clear_n   (clear_n),
      .sensor    (sensor),
      .cntry     (cntry),
      .X         (X),
      .car_count (car_count),
      .overflow  (overflow)
   );

   always #5 clock = ~clock;

   // ---------------- behavioural reference model ----------------
   // The sensor reaches the debouncer two edges late; a level is accepted once
   // the last DEBOUNCE observed samples all disagree with the current level.
   bit m_s1, m_s2;
   bit hist[$];
   bit m_present;
   int m_green_run;
   int m_count;
   bit m_ovf;

   task automatic model_reset();
      m_s1 = 0; m_s2 = 0;
      hist.delete();
      m_present = 0; m_green_run = 0; m_count = 0; m_ovf = 0;
   endtask

   task automatic model_step(input bit s_in, input logic [1:0] c_in);
      bit samp, arr, dep, flip;
      samp = m_s2;
      m_s2 = m_s1;
      m_s1 = s_in;
      hist.push_back(samp);
      if (hist.size() > DEBOUNCE) void'(hist.pop_front());
      arr  = 0;
      flip = (hist.size() == DEBOUNCE);
      foreach (hist[i]) if (hist[i] == m_present) flip = 0;
      if (flip) begin
         if (!m_present) arr = 1;
         m_present = !m_present;
      end
      dep = 0;
      if (c_in == GREEN && m_count != 0) begin
         m_green_run++;
         if (m_green_run == DEPART_CYCLES) begin
            dep = 1;
            m_green_run = 0;
         end
      end else begin
         m_green_run = 0;
      end
      if (arr && !dep) begin
         if (m_count == MAX_CARS) m_ovf = 1;
         else m_count++;
      end else if (dep && !arr) begin
         m_count--;
      end
   endtask

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] actual, input int expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, actual, expected, $time);
      end
   endtask

   task automatic check_outs(input string name, input int exp_count, input int exp_ovf);
      check({name, ".car_count"}, 32'(car_count), exp_count);
      check({name, ".X"}, 32'(X), (exp_count != 0) ? 1 : 0);
      check({name, ".overflow"}, 32'(overflow), exp_ovf);
   endtask

   // One clock edge with the currently driven inputs; returns 1 time unit after the edge
   task automatic tick();
      @(posedge clock);
      if (clear_n) model_step(sensor, cntry);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // One clean debounced car: arrival lands on the 5th tick, FSM back to IDLE by the next call
   task automatic car(input logic [1:0] c);
      cntry  = c;
      sensor = 1'b1;
      ticks(4);
      sensor = 1'b0;
      ticks(4);
   endtask

   task automatic do_reset();
      clear_n = 1'b0;
      model_reset();
      @(posedge clock);
      #1;
      clear_n = 1'b1;
   endtask

   typedef struct {
      bit         sensor;
      logic [1:0] cntry;
      int         exp_count;
      int         exp_ovf;
   } vec_t;

   vec_t tbl[NVEC];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_seq[7];
      logic [1:0] cseq[7];
      int run_s, run_c;

      // Glitch (2 cycles high) followed by one car of 8 cycles with a 1-cycle gap at step 16
      for (int i = 0; i < NVEC; i++) begin
         tbl[i].sensor    = (i < 2) || (i >= 8 && i <= 15) || (i >= 17 && i <= 19);
         tbl[i].cntry     = RED;
         tbl[i].exp_count = (i >= 12) ? 1 : 0;
         tbl[i].exp_ovf   = 0;
      end

      // Reset state
      model_reset();
      ticks(2);
      check_outs("reset_state", 0, 0);
      clear_n = 1'b1;

      // Vector table
      for (int i = 0; i < NVEC; i++) begin
         sensor = tbl[i].sensor;
         cntry  = tbl[i].cntry;
         tick();
         check_outs($sformatf("vec%0d", i), tbl[i].exp_count, tbl[i].exp_ovf);
      end

      // Departure with continuous GREEN from 3 cars
      car(RED); car(RED);
      check_outs("dep_pre", 3, 0);
      exp_seq = '{3, 2, 2, 1, 1, 0, 0};
      cntry = GREEN;
      for (int i = 0; i < 7; i++) begin
         tick();
         check_outs($sformatf("dep_g%0d", i), exp_seq[i], 0);
      end
      cntry = RED;

      // Departure with one YELLOW cycle at g+2
      car(RED); car(RED); car(RED);
      check_outs("depy_pre", 3, 0);
      exp_seq = '{3, 2, 2, 2, 1, 1, 0};
      cseq    = '{GREEN, GREEN, YELLOW, GREEN, GREEN, GREEN, GREEN};
      for (int i = 0; i < 7; i++) begin
         cntry = cseq[i];
         tick();
         check_outs($sformatf("depy_g%0d", i), exp_seq[i], 0);
      end
      cntry = RED;

      // Saturation: 8 arrivals with RED
      for (int i = 1; i <= 8; i++) begin
         car(RED);
         check_outs($sformatf("sat_car%0d", i), (i > MAX_CARS) ? MAX_CARS : i, (i > MAX_CARS) ? 1 : 0);
      end
      cntry = GREEN;
      ticks(16);
      check_outs("sat_drained", 0, 1);
      cntry = RED;

      // Asynchronous reset mid-departure and mid-debounce
      car(RED); car(RED); car(RED);
      cntry  = GREEN;
      sensor = 1'b1;
      tick();
      check_outs("rst_pre", 3, 1);
      #2;
      clear_n = 1'b0;
      #1;
      check_outs("rst_async", 0, 0);
      model_reset();
      @(posedge clock);
      #1;
      clear_n = 1'b1;
      cntry   = RED;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_outs($sformatf("rst_lat%0d", i), (i == 4) ? 1 : 0, 0);
      end

      // Arrival and departure on the same edge with 4 queued
      sensor = 1'b0;
      ticks(6);
      car(RED); car(RED); car(RED);
      check_outs("sim_pre", 4, 0);
      sensor = 1'b1;
      cntry  = RED;
      ticks(3);
      cntry = GREEN;
      tick();
      check_outs("sim_t3", 4, 0);
      tick();
      check_outs("sim_t4", 4, 0);
      cntry  = RED;
      sensor = 1'b0;
      tick();
      check_outs("sim_t5", 4, 0);

      // Randomized traffic against the model
      ticks(6);
      do_reset();
      run_s = 0;
      run_c = 0;
      for (int i = 0; i < 3000; i++) begin
         if (run_s == 0) begin
            sensor = 1'($urandom_range(0, 1));
            run_s  = int'($urandom_range(1, 7));
         end
         if (run_c == 0) begin
            cntry = ($urandom_range(0, 9) < 4) ? GREEN : 2'($urandom_range(0, 3));
            run_c = int'($urandom_range(1, 10));
         end
         run_s--;
         run_c--;
         tick();
         check_outs("rand", m_count, int'(m_ovf));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
